// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that time-shares one 8:1 mux among eight requesters.
// A holder keeps the mux while it requests, but once it has held MAX_HOLD
// consecutive cycles and someone else is waiting, the grant moves on.
// The selected data bit is registered on every granted edge.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       vld,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0] state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] sel_reg, sel_next;
  logic       y_reg, y_next;
  logic       vld_reg, vld_next;

  // Requests rotated so that bit 0 is the one at the round-robin pointer;
  // the second copy masks out the current holder for quota handover.
  logic [7:0] rot_all, rot_ex;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      logic [2:0] idx;
      assign idx         = ptr_reg + 3'(gi);
      assign rot_all[gi] = req[idx];
      assign rot_ex[gi]  = req[idx] && (idx != sel_reg);
    end
  endgenerate

  logic       found_all, found_ex;
  logic [2:0] off_all, off_ex;
  logic [2:0] win_all, win_ex;

  // Lowest set offset in each rotated vector is the round-robin winner.
  always_comb begin
    found_all = 1'b0;
    found_ex  = 1'b0;
    off_all   = 3'd0;
    off_ex    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_all[k]) begin
        found_all = 1'b1;
        off_all   = 3'(k);
      end
      if (rot_ex[k]) begin
        found_ex = 1'b1;
        off_ex   = 3'(k);
      end
    end
  end

  assign win_all = ptr_reg + off_all;
  assign win_ex  = ptr_reg + off_ex;

  logic       do_grant;
  logic [2:0] grant_idx;

  // Next-state decision: new grant, hold, release to idle, or quota handover.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    y_next     = y_reg;
    vld_next   = vld_reg;
    do_grant   = 1'b0;
    grant_idx  = win_all;

    case (state_reg)
      ST_IDLE: begin
        vld_next = 1'b0;
        if (found_all) begin
          do_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        y_next   = d[sel_reg];
        vld_next = 1'b1;
        if (!req[sel_reg]) begin
          // Holder let go; any requester may win, including from the pointer.
          if (found_all) begin
            do_grant = 1'b1;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = 8'h00;
          end
        end else if (cnt_reg >= HOLD_MAX && found_ex) begin
          do_grant  = 1'b1;
          grant_idx = win_ex;
        end else if (cnt_reg < HOLD_MAX) begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = 8'h00;
      end
    endcase

    if (do_grant) begin
      state_next = ST_GRANT;
      gnt_next   = 8'b1 << grant_idx;
      sel_next   = grant_idx;
      cnt_next   = 4'd1;
      ptr_next   = grant_idx + 3'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 3'd0;
      cnt_reg   <= 4'd0;
      gnt_reg   <= 8'h00;
      sel_reg   <= 3'd0;
      y_reg     <= 1'b0;
      vld_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      y_reg     <= y_next;
      vld_reg   <= vld_next;
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign y    = y_reg;
  assign vld  = vld_reg;
  assign busy = (state_reg == ST_GRANT);

endmodule
